// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the shadow-result record.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MFHI  = 3'd4;
    localparam logic [2:0] MD_MFLO  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    localparam logic MD_IDLE = 1'b0;
    localparam logic MD_BUSY = 1'b1;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_result_t;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO. Results are computed at issue
// into shadow registers and committed to HI/LO after a fixed latency.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    logic        state;
    logic [4:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    md_result_t  result;
    logic        issue;

    // Division runs on magnitudes and fixes signs afterwards; this also makes
    // 0x80000000 / -1 wrap to 0x80000000 without a special case.
    function automatic md_result_t md_compute(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        md_result_t         r;
        logic signed [63:0] sprod;
        logic [63:0]        uprod;
        logic               sgn;
        logic [31:0]        mag_a;
        logic [31:0]        mag_b;
        logic [31:0]        divisor;
        logic [31:0]        quo;
        logic [31:0]        rem;
        r       = '0;
        sprod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod   = {32'd0, a} * {32'd0, b};
        sgn     = (op == MD_DIV);
        mag_a   = (sgn && a[31]) ? -a : a;
        mag_b   = (sgn && b[31]) ? -b : b;
        divisor = (b == 32'd0) ? 32'd1 : mag_b;
        quo     = mag_a / divisor;
        rem     = mag_a % divisor;
        case (op)
            MD_MULT: begin
                {r.hi, r.lo} = sprod;
                r.wr = 1'b1;
            end
            MD_MULTU: begin
                {r.hi, r.lo} = uprod;
                r.wr = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                r.lo = (sgn && (a[31] ^ b[31])) ? -quo : quo;
                r.hi = (sgn && a[31]) ? -rem : rem;
                // A zero divisor still runs the full latency but commits nothing.
                r.wr = (b != 32'd0);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign result = md_compute(md_op, operand1, operand2);
    assign issue  = start && (md_op[2] == 1'b0);
    assign busy   = (state == MD_BUSY);

    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI)
            md_out = hi;
        else if (md_op == MD_MFLO)
            md_out = lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MD_IDLE;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (issue) begin
                        res_hi <= result.hi;
                        res_lo <= result.lo;
                        res_wr <= result.wr;
                        cnt    <= md_op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        state  <= MD_BUSY;
                    end else if (md_we && md_op == MD_MTHI) begin
                        hi <= operand1;
                    end else if (md_we && md_op == MD_MTLO) begin
                        lo <= operand1;
                    end
                end
                default: begin
                    if (cnt <= 5'd1) begin
                        cnt   <= 5'd0;
                        state <= MD_IDLE;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO and latency are queued at
// issue and compared when busy falls.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        md_we;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
        .operand1(operand1), .operand2(operand2), .busy(busy), .hi(hi),
        .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t           e;
        longint         sa, sbv, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]    p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.lat = op[1] ? MD_DIV_CYCLES : MD_MULT_CYCLES;
        if (op == MD_MULT) begin
            p = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op == MD_MULTU) begin
            p = ua * ub;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b != 32'd0) begin
            if (op == MD_DIV) begin
                sq = sa / sbv;
                sr = sa % sbv;
                e.lo = sq[31:0];
                e.hi = sr[31:0];
            end else begin
                uq = ua / ub;
                ur = ua % ub;
                e.lo = uq[31:0];
                e.hi = ur[31:0];
            end
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(op, a, b));
        start = 1'b1; md_op = op; operand1 = a; operand2 = b;
        tick;
        start = 1'b0; md_op = MD_MFLO;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_busy op=%0d: busy=%b required 1", op, busy);
        end
    endtask

    task automatic wait_commit(input string name, input bit inject);
        exp_t e;
        int   n;
        bit   done;
        n = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (inject && n == 1) begin
                start = 1'b1; md_op = MD_MULT; operand1 = 32'd5; operand2 = 32'd7;
            end else if (inject && n == 2) begin
                start = 1'b0; md_op = MD_MTLO; md_we = 1'b1; operand1 = 32'hDEAD;
            end else begin
                start = 1'b0; md_we = 1'b0; md_op = MD_MFLO;
            end
            tick;
            n++;
            if (!busy) done = 1;
            else begin
                checks++;
                if (hi !== m_hi || lo !== m_lo) begin
                    errors++;
                    $display("FAIL %s_shadow_visible: hi=%h lo=%h required %h %h", name, hi, lo, m_hi, m_lo);
                end
            end
        end
        start = 1'b0; md_we = 1'b0; md_op = MD_MFLO;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", name, busy, n);
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: no expected entry queued, required 1", name);
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (n != e.lat) begin
                errors++;
                $display("FAIL %s_latency: busy cycles=%0d required %0d", name, n, e.lat);
            end
            if (hi !== e.hi) begin
                errors++;
                $display("FAIL %s_hi: hi=%h required %h", name, hi, e.hi);
            end
            if (lo !== e.lo) begin
                errors++;
                $display("FAIL %s_lo: lo=%h required %h", name, lo, e.lo);
            end
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic check_mf(input string name);
        md_op = MD_MFHI; #1;
        checks++;
        if (md_out !== m_hi) begin
            errors++;
            $display("FAIL %s_mfhi: md_out=%h required %h", name, md_out, m_hi);
        end
        md_op = MD_MFLO; #1;
        checks++;
        if (md_out !== m_lo) begin
            errors++;
            $display("FAIL %s_mflo: md_out=%h required %h", name, md_out, m_lo);
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] v);
        md_op = op; md_we = 1'b1; operand1 = v;
        tick;
        md_we = 1'b0; md_op = MD_MFLO;
        if (op == MD_MTHI) m_hi = v; else m_lo = v;
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL move_%0d: hi=%h lo=%h required %h %h", op, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; md_we = 1'b0; md_op = MD_MFHI;
        operand1 = 32'd0; operand2 = 32'd0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: hi=%h required 0", hi); end
        if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: lo=%h required 0", lo); end
        if (md_out !== 32'd0) begin errors++; $display("FAIL reset_md_out: md_out=%h required 0", md_out); end
    endtask

    task automatic test_mult;
        issue(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        wait_commit("mult", 0);
        check_mf("mult");
    endtask

    task automatic test_multu;
        issue(MD_MULTU, 32'hFFFFFFFE, 32'h00000003);
        wait_commit("multu", 0);
        check_mf("multu");
    endtask

    task automatic test_div;
        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_commit("div", 0);
        issue(MD_DIVU, 32'hFFFFFFF9, 32'h00000010);
        wait_commit("divu", 0);
        check_mf("div");
    endtask

    task automatic test_divzero;
        move_to(MD_MTHI, 32'h00001234);
        move_to(MD_MTLO, 32'h00005678);
        issue(MD_DIVU, 32'd7, 32'd0);
        wait_commit("divu_zero", 0);
        issue(MD_DIV, 32'hFFFFFF00, 32'd0);
        wait_commit("div_zero", 0);
        check_mf("divzero");
    endtask

    task automatic test_overflow;
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_commit("div_ovf", 0);
        check_mf("div_ovf");
    endtask

    task automatic test_ignore_busy;
        issue(MD_MULT, 32'h00010000, 32'h00010000);
        wait_commit("ignore", 1);
        tick;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_restart: busy=%b required 0", busy); end
        if (lo !== m_lo) begin errors++; $display("FAIL ignore_mtlo: lo=%h required %h", lo, m_lo); end
        md_op = MD_MTHI; #1;
        checks++;
        if (md_out !== 32'd0) begin errors++; $display("FAIL md_out_other: md_out=%h required 0", md_out); end
    endtask

    task automatic test_back_to_back;
        issue(MD_MULT, 32'd3, 32'hFFFFFFFC);
        wait_commit("b2b_first", 0);
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_commit("b2b_second", 0);
        check_mf("b2b");
    endtask

    task automatic test_reset_midop;
        move_to(MD_MTHI, 32'hAAAA5555);
        issue(MD_DIV, 32'd1000, 32'd3);
        tick; tick;
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: busy=%b required 0", busy); end
        if (hi !== 32'd0) begin errors++; $display("FAIL midreset_hi: hi=%h required 0", hi); end
        if (lo !== 32'd0) begin errors++; $display("FAIL midreset_lo: lo=%h required 0", lo); end
        sb.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                errors++;
                $display("FAIL midreset_no_commit: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_divzero;
        test_overflow;
        test_ignore_busy;
        test_back_to_back;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
